// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the RAM port arbiter.
package ram_port_arbiter_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  localparam int unsigned WordW = 32;
  localparam int unsigned BeW   = 4;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_rr_arb.sv
// Combinational round-robin pick: lowest requester at or after the pointer, wrapping.
module ram_port_rr_arb
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = idx_w(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);

  always_comb begin
    int unsigned w_cand;
    w_cand  = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      // i_ptr is always below N, so one subtraction implements the wrap.
      w_cand = 32'(i_ptr) + off;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      if (!o_valid && i_req[w_cand[IdxW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = w_cand[IdxW-1:0];
      end
    end
    if (o_valid) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port among NumHosts requesters with round-robin arbitration,
// 1-cycle response routing and an optional post-reset zero-fill.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned NumHosts = 3,
  parameter int unsigned Depth    = 128,
  parameter bit          ZeroInit = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumHosts-1:0]              host_req_i,
  input  logic [NumHosts-1:0]              host_we_i,
  input  logic [NumHosts-1:0][BeW-1:0]     host_be_i,
  input  logic [NumHosts-1:0][WordW-1:0]   host_addr_i,
  input  logic [NumHosts-1:0][WordW-1:0]   host_wdata_i,
  output logic [NumHosts-1:0]              host_gnt_o,
  output logic [NumHosts-1:0]              host_rvalid_o,
  output logic [NumHosts-1:0][WordW-1:0]   host_rdata_o,
  output logic                             ram_req_o,
  output logic                             ram_we_o,
  output logic [BeW-1:0]                   ram_be_o,
  output logic [WordW-1:0]                 ram_addr_o,
  output logic [WordW-1:0]                 ram_wdata_o,
  input  logic                             ram_rvalid_i,
  input  logic [WordW-1:0]                 ram_rdata_i,
  output logic                             init_done_o
);

  localparam int unsigned     IdxW       = idx_w(NumHosts);
  localparam int unsigned     CntW       = idx_w(Depth);
  localparam logic [CntW-1:0] CntLast    = CntW'(Depth - 1);
  localparam logic [IdxW-1:0] PtrLast    = IdxW'(NumHosts - 1);
  localparam arb_state_e      ResetState = ZeroInit ? INIT : RUN;

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [CntW-1:0]       r_cnt;
  logic [CntW-1:0]       w_cnt_nxt;
  logic [IdxW-1:0]       r_ptr;
  logic [IdxW-1:0]       r_owner;
  logic                  r_pending;
  logic                  r_init_done;
  logic                  w_grant;
  logic [NumHosts-1:0]   w_arb_gnt;
  logic [IdxW-1:0]       w_arb_idx;
  logic                  w_arb_valid;

  ram_port_rr_arb #(
    .N    (NumHosts),
    .IdxW (IdxW)
  ) u_rr_arb (
    .i_req   (host_req_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ResetState;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    host_gnt_o  = '0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    case (r_state)
      INIT: begin
        ram_req_o  = 1'b1;
        ram_we_o   = 1'b1;
        ram_be_o   = '1;
        ram_addr_o = {{(WordW - CntW - 2){1'b0}}, r_cnt, 2'b00};
        // The counter parks on the last word instead of wrapping.
        if (r_cnt == CntLast) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (w_arb_valid) begin
          w_grant     = 1'b1;
          host_gnt_o  = w_arb_gnt;
          ram_req_o   = 1'b1;
          ram_we_o    = host_we_i[w_arb_idx];
          ram_be_o    = host_be_i[w_arb_idx];
          ram_addr_o  = host_addr_i[w_arb_idx];
          ram_wdata_o = host_wdata_i[w_arb_idx];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_pending   <= 1'b0;
      r_init_done <= !ZeroInit;
    end else begin
      r_pending   <= w_grant;
      r_init_done <= (w_state_nxt == RUN);
      if (w_grant) begin
        r_owner <= w_arb_idx;
        r_ptr   <= (w_arb_idx == PtrLast) ? '0 : w_arb_idx + 1'b1;
      end
    end
  end

  // Zero-fill writes never set r_pending, so their responses are swallowed here.
  always_comb begin
    host_rvalid_o = '0;
    if (r_pending && ram_rvalid_i) begin
      host_rvalid_o[r_owner] = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < NumHosts; k++) begin
      host_rdata_o[k] = ram_rdata_i;
    end
  end

  assign init_done_o = r_init_done;

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(host_gnt_o));
  a_rvalid_after_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ram_rvalid_i |-> $past(ram_req_o));
  a_no_gnt_before_init : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !init_done_o |-> (host_gnt_o == '0));
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomized checks of ram_port_arbiter against a behavioural model.
module tb_ram_port_arbiter;
  localparam int N = 3;
  localparam int D = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [N-1:0]        req, we, gnt, rvalid;
  logic [N-1:0][3:0]   be;
  logic [N-1:0][31:0]  addr, wdata, rdata;
  logic                ram_req, ram_we, init_done;
  logic [3:0]          ram_be;
  logic [31:0]         ram_addr, ram_wdata;
  logic                ram_rvalid = 1'b0;
  logic [31:0]         ram_rdata = 32'h0;

  logic [N-1:0]        z_req, z_we, z_gnt, z_rvalid;
  logic [N-1:0][3:0]   z_be;
  logic [N-1:0][31:0]  z_addr, z_wdata, z_rdata;
  logic                z_ram_req, z_ram_we, z_init_done;
  logic [3:0]          z_ram_be;
  logic [31:0]         z_ram_addr, z_ram_wdata;
  logic                z_ram_rvalid = 1'b0;
  logic [31:0]         z_ram_rdata;
  assign z_ram_rdata = 32'h0;

  ram_port_arbiter #(.NumHosts(N), .Depth(D), .ZeroInit(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(req), .host_we_i(we), .host_be_i(be), .host_addr_i(addr), .host_wdata_i(wdata),
    .host_gnt_o(gnt), .host_rvalid_o(rvalid), .host_rdata_o(rdata),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata),
    .init_done_o(init_done)
  );

  ram_port_arbiter #(.NumHosts(N), .Depth(D), .ZeroInit(1'b0)) dut_nz (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(z_req), .host_we_i(z_we), .host_be_i(z_be), .host_addr_i(z_addr), .host_wdata_i(z_wdata),
    .host_gnt_o(z_gnt), .host_rvalid_o(z_rvalid), .host_rdata_o(z_rdata),
    .ram_req_o(z_ram_req), .ram_we_o(z_ram_we), .ram_be_o(z_ram_be), .ram_addr_o(z_ram_addr),
    .ram_wdata_o(z_ram_wdata), .ram_rvalid_i(z_ram_rvalid), .ram_rdata_i(z_ram_rdata),
    .init_done_o(z_init_done)
  );

  // RAM behind the port: 1-cycle latency, starts full of garbage.
  logic [31:0] mem [D];
  logic        seeded = 1'b0;
  always @(posedge clk) begin : ram_model
    logic [31:0] merged;
    ram_rvalid <= ram_req;
    if (!seeded) begin
      for (int i = 0; i < D; i++) mem[i] <= $urandom;
      seeded <= 1'b1;
    end else if (ram_req) begin
      merged = mem[ram_addr[5:2]];
      for (int b = 0; b < 4; b++) if (ram_be[b]) merged[8*b +: 8] = ram_wdata[8*b +: 8];
      if (ram_we) begin
        mem[ram_addr[5:2]] <= merged;
        ram_rdata <= 32'h0;
      end else begin
        ram_rdata <= mem[ram_addr[5:2]];
      end
    end
  end

  always @(posedge clk) z_ram_rvalid <= z_ram_req;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mmem [D];
  int          mptr, exp_owner, last_w;
  bit          exp_pend, exp_read;
  logic [31:0] exp_data, last_rdata;
  logic [N-1:0] last_rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_read(input int k, input logic [31:0] a);
    req[k] = 1'b1; we[k] = 1'b0; be[k] = 4'hF; addr[k] = a; wdata[k] = 32'h0;
  endtask

  task automatic set_write(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req[k] = 1'b1; we[k] = 1'b1; be[k] = b; addr[k] = a; wdata[k] = d;
  endtask

  task automatic rand_host(input int k);
    req[k]   = 1'($urandom_range(0, 1));
    we[k]    = 1'($urandom_range(0, 1));
    be[k]    = 4'($urandom_range(1, 15));
    addr[k]  = 32'($urandom_range(0, D - 1)) << 2;
    wdata[k] = $urandom;
  endtask

  task automatic init_check(input int i);
    chk("init_req", 32'(ram_req), 32'd1);
    chk("init_we", 32'(ram_we), 32'd1);
    chk("init_be", 32'(ram_be), 32'hF);
    chk("init_addr", ram_addr, 32'(i * 4));
    chk("init_wdata", ram_wdata, 32'h0);
    chk("init_gnt", 32'(gnt), 32'h0);
    chk("init_rvalid", 32'(rvalid), 32'h0);
    chk("init_done_low", 32'(init_done), 32'h0);
  endtask

  task automatic init_cycle(input int i);
    @(negedge clk);
    init_check(i);
    @(posedge clk); #1;
  endtask

  // One RUN cycle: the winner is the first requester scanning from the model
  // pointer; the response returns one cycle later to that winner.
  task automatic run_cycle();
    int w;
    int widx;
    logic [N-1:0] egnt, erv;
    logic [31:0] merged;
    @(negedge clk);
    w = -1;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (mptr + i) % N;
      if (w < 0 && req[c]) w = c;
    end
    egnt = '0;
    if (w >= 0) egnt[w] = 1'b1;
    erv = '0;
    if (exp_pend) erv[exp_owner] = 1'b1;
    chk("init_done", 32'(init_done), 32'd1);
    chk("gnt", 32'(gnt), 32'(egnt));
    chk("rvalid", 32'(rvalid), 32'(erv));
    last_rv = rvalid;
    if (exp_pend && exp_read) begin
      last_rdata = rdata[exp_owner];
      chk("rdata", rdata[exp_owner], exp_data);
    end
    chk("ram_req", 32'(ram_req), (w >= 0) ? 32'd1 : 32'd0);
    if (w >= 0) begin
      chk("ram_addr", ram_addr, addr[w]);
      chk("ram_wdata", ram_wdata, wdata[w]);
      chk("ram_we", 32'(ram_we), 32'(we[w]));
      chk("ram_be", 32'(ram_be), 32'(be[w]));
      exp_owner = w;
      exp_read  = !we[w];
      widx      = int'(addr[w][5:2]);
      if (!we[w]) begin
        exp_data = mmem[widx];
      end else begin
        merged = mmem[widx];
        for (int b = 0; b < 4; b++) if (be[w][b]) merged[8*b +: 8] = wdata[w][8*b +: 8];
        mmem[widx] = merged;
      end
      mptr = (w + 1) % N;
    end else begin
      chk("idle_addr", ram_addr, 32'h0);
      chk("idle_wdata", ram_wdata, 32'h0);
      chk("idle_we_be", {27'h0, ram_we, ram_be}, 32'h0);
    end
    exp_pend = (w >= 0);
    last_w   = w;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    z_req = '0; z_we = '0; z_be = '0; z_addr = '0; z_wdata = '0;
    mptr = 0; exp_pend = 1'b0; exp_read = 1'b0; exp_owner = 0; last_w = -1;
    exp_data = '0; last_rdata = '0; last_rv = '0;

    @(negedge clk); @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_ram_req", 32'(ram_req), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);
    chk("nz_rst_init_done", 32'(z_init_done), 32'd1);
    chk("nz_rst_ram_req", 32'(z_ram_req), 32'd0);
    chk("nz_rst_gnt", 32'(z_gnt), 32'h0);
    chk("nz_rst_addr", z_ram_addr, 32'h0);
    chk("nz_rst_we_be", {27'h0, z_ram_we, z_ram_be}, 32'h0);

    // All hosts request throughout INIT; none may be granted.
    for (int k = 0; k < N; k++) set_read(k, 32'($urandom_range(0, D - 1)) << 2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    z_req = 3'b010; z_we = '0; z_be[1] = 4'hF; z_addr[1] = 32'h24;
    @(negedge clk);
    init_check(0);
    chk("nz_first_gnt", 32'(z_gnt), 32'h2);
    chk("nz_first_req", 32'(z_ram_req), 32'd1);
    chk("nz_first_addr", z_ram_addr, 32'h24);
    @(posedge clk); #1;
    z_req = '0;
    @(negedge clk);
    init_check(1);
    chk("nz_rvalid", 32'(z_rvalid), 32'h2);
    chk("nz_idle_gnt", 32'(z_gnt), 32'h0);
    @(posedge clk); #1;
    for (int i = 2; i < D; i++) init_cycle(i);
    for (int i = 0; i < D; i++) mmem[i] = 32'h0;

    // Continuous requests from all hosts: strict rotation.
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      chk("rr_order", 32'(last_w), 32'(i % N));
      if (last_w >= 0) begin
        if (i < 3) set_read(last_w, 32'($urandom_range(0, D - 1)) << 2);
        else req[last_w] = 1'b0;
      end
    end
    run_cycle();

    set_read(0, 32'h20);
    run_cycle();
    req[0] = 1'b0;
    run_cycle();
    chk("zero_fill_0x20", last_rdata, 32'h0);

    set_write(1, 32'h8, 32'hDEADBEEF, 4'b0011);
    run_cycle();
    req[1] = 1'b0;
    set_read(2, 32'h8);
    run_cycle();
    req[2] = 1'b0;
    run_cycle();
    chk("partial_write_read", last_rdata, 32'h0000BEEF);
    chk("h1_rvalid_quiet", 32'(last_rv[1]), 32'h0);
    chk("h2_rvalid", 32'(last_rv[2]), 32'h1);

    for (int i = 0; i < 3; i++) begin
      set_read(2, 32'($urandom_range(0, D - 1)) << 2);
      run_cycle();
      chk("h2_alone", 32'(last_w), 32'd2);
    end
    set_read(0, 32'h10);
    set_read(2, 32'h14);
    run_cycle();
    chk("ptr_wrap_win", 32'(last_w), 32'd0);
    req[0] = 1'b0;
    run_cycle();
    chk("ptr_wrap_next", 32'(last_w), 32'd2);
    req[2] = 1'b0;
    run_cycle();

    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++) if (!req[k] || last_w == k) rand_host(k);
      run_cycle();
    end
    for (int i = 0; i < 8 && req != '0; i++) begin
      run_cycle();
      if (last_w >= 0) req[last_w] = 1'b0;
    end
    chk("drain", 32'(req), 32'h0);
    run_cycle();

    // Reset while a read response is in flight.
    set_read(0, 32'h4);
    run_cycle();
    req[0] = 1'b0;
    rst_n = 1'b0;
    mptr = 0; exp_pend = 1'b0;
    @(negedge clk);
    chk("rst_inflight_rvalid", 32'(rvalid), 32'h0);
    chk("rst_inflight_addr", ram_addr, 32'h0);
    chk("rst_inflight_done", 32'(init_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) init_cycle(i);

    // Reset during INIT with the counter at 5.
    @(negedge clk);
    init_check(5);
    rst_n = 1'b0;
    #1;
    chk("rst_cnt5_addr", ram_addr, 32'h0);
    chk("rst_cnt5_req", 32'(ram_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) init_cycle(i);
    for (int i = 0; i < D; i++) mmem[i] = 32'h0;

    set_read(0, 32'h10);
    set_read(1, 32'h3C);
    run_cycle();
    chk("ptr_after_reset", 32'(last_w), 32'd0);
    req[0] = 1'b0;
    run_cycle();
    req[1] = 1'b0;
    run_cycle();
    chk("refill_0x3c", last_rdata, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares one port of the 32-bit dual-port RAM among `NumHosts` requesters, such as core data, debug module and DMA. It uses work-conserving round-robin arbitration and routes each 1-cycle-latency response back to the host that issued it. An optional zero-fill engine runs after reset and writes every word before any host is granted. The block sits directly between the hosts and one `a_*`/`b_*` port of the RAM wrapper.

## Interface
- `NumHosts`, default 3: number of requesters; legal range 2..8.
- `Depth`, default 128: RAM depth in 32-bit words; power of two.
- `ZeroInit`, default 1'b1: when 1, zero-fill the RAM after every reset.
- `clk_i`  in  1  clock; the only clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `host_req_i`  in  NumHosts  per-host request; held until granted.
- `host_we_i`  in  NumHosts  per-host write enable.
- `host_be_i`  in  NumHosts x 4  per-host byte enables.
- `host_addr_i`  in  NumHosts x 32  per-host byte address.
- `host_wdata_i`  in  NumHosts x 32  per-host write data.
- `host_gnt_o`  out  NumHosts  one-hot grant; request accepted this cycle.
- `host_rvalid_o`  out  NumHosts  response valid, routed to the owning host.
- `host_rdata_o`  out  NumHosts x 32  `ram_rdata_i` broadcast to all hosts.
- `ram_req_o`, `ram_we_o`  out  1 each  RAM request and write enable.
- `ram_be_o`  out  4  RAM byte enables.
- `ram_addr_o`, `ram_wdata_o`  out  32 each  RAM address and write data.
- `ram_rvalid_i`  in  1  RAM response valid; arrives 1 cycle after `ram_req_o`.
- `ram_rdata_i`  in  32  RAM read data.
- `init_done_o`  out  1  high once the RAM is usable by hosts.

## Operation
- FSM states: INIT, RUN. Reset enters INIT if `ZeroInit`, else RUN.
- INIT state:
  - Drives `ram_req_o`=1, `ram_we_o`=1, `ram_be_o`=4'hF, `ram_wdata_o`=0 and `ram_addr_o`={cnt,2'b00}.
  - Counter `cnt` runs 0..Depth-1, one word per cycle.
  - After the write at `cnt`=Depth-1 the FSM moves to RUN; `init_done_o` rises the following cycle.
  - `host_gnt_o` stays 0 throughout INIT.
  - `ram_rvalid_i` is consumed and never forwarded to any host.
- RUN state, arbitration:
  - Grant is combinational from `host_req_i` and a priority pointer `ptr`.
  - The lowest requesting index at or after `ptr`, wrapping modulo NumHosts, wins.
  - At most one grant per cycle. No grant is issued without a request.
- RUN state, grant side effects:
  - `ptr` becomes (k+1) mod NumHosts, where k is the winner.
  - `ptr` is unchanged on idle cycles.
  - The RAM outputs mux host k's `we`/`be`/`addr`/`wdata`, and `ram_req_o`=1.
- RUN state, idle cycle: `ram_req_o`=0, and the other RAM outputs are 0.
- Response routing:
  - On each grant, `owner_q` ← k and `pending_q` ← 1; otherwise `pending_q` ← 0.
  - `host_rvalid_o[owner_q]` = `ram_rvalid_i` & `pending_q`.
  - Writes also return rvalid; hosts ignore the data.
- Widths:
  - `owner_q` and `ptr` are $clog2(NumHosts) bits.
  - `cnt` is $clog2(Depth) bits and stops at Depth-1, with no wrap.
- A host dropping `req` before `gnt` is a protocol violation; behaviour is undefined but it must not deadlock other hosts.
- Reset mid-operation:
  - All state clears: `ptr`=0, `pending_q`=0.
  - INIT restarts from `cnt`=0.
  - A response in flight is dropped.

## Timing
- Reset values:
  - `host_gnt_o`=0, `host_rvalid_o`=0.
  - `ram_req_o`=ZeroInit; in INIT the first write issues in the first cycle after reset release.
  - `init_done_o`=!ZeroInit.
  - All other outputs 0.
- Grant latency: 0 cycles (same cycle as the request in RUN). Response latency: 1 cycle after the grant.
- Throughput is one access per cycle, back-to-back. Grants to different hosts on consecutive cycles route responses correctly.
- INIT duration is Depth cycles; `init_done_o` rises at cycle Depth+1 after reset release.
- Simultaneous events: when the response to host j and a new grant to host k share a cycle, the new grant is handled independently of the returning response.

## Structure
- Package `ram_port_arbiter_pkg` holds the `arb_state_e` enum {INIT, RUN}.
- Sub-module `ram_port_rr_arb` #(N): a combinational round-robin pick from the request vector and `ptr`, outputting a one-hot grant and a binary index. The pointer register stays in the parent.
- Assertions:
  - `host_gnt_o` is one-hot0.
  - `ram_rvalid_i` implies `ram_req_o` was high in the previous cycle.
  - `host_gnt_o` is 0 while `init_done_o`=0.

## Test plan
- Reset with Depth=16, ZeroInit=1 -> 16 consecutive writes to addresses 0x00..0x3C with data 0 and be=F, no grants, `init_done_o` high at cycle 17; a read of 0x20 then returns 0.
- All 3 hosts request continuously -> grants 0,1,2,0,1,2 in consecutive cycles; each `host_rvalid_o[k]` pulses exactly 1 cycle after its grant.
- Host 1 writes 0xDEADBEEF at 0x8 with be=4'b0011, then host 2 reads 0x8 -> host 2 receives 0x0000BEEF and host 1's rvalid is not asserted.
- Host 2 requests alone for 3 cycles, then hosts 0 and 2 request together -> host 0 wins, since `ptr` wrapped to 0.
- Assert `rst_ni` during INIT at `cnt`=5, and separately during a pending read -> INIT restarts at address 0, and no stray `host_rvalid_o` appears.
- ZeroInit=0 -> `init_done_o`=1 at reset release, and a request in the first cycle after reset release is granted that same cycle.
